// File: rtl/dist_telemetry_framer.sv
`default_nettype none
// ============================================================================
// Module   : dist_telemetry_framer
// Brief    : N-channel distance sample latch, round-robin arbiter, binary to
//            decimal ASCII converter and "<ID>:<digits>\r\n" byte framer.
// Revision : 1.0 - initial release
// ============================================================================
module dist_telemetry_framer #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic [N_CH-1:0]          sample_valid,
  input  logic [N_CH*DATA_W-1:0]   sample_data,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [N_CH-1:0]          overrun
);

  localparam int          c_ch_w   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int          c_cnt_w  = $clog2(DATA_W + 1);
  localparam int          c_dig_w  = $clog2(DIGITS + 1);
  localparam int          c_bcd_w  = DIGITS * 4;
  localparam logic [63:0] c_max_val = 64'(10 ** DIGITS) - 64'd1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD       = 4'd1,
    S_CONVERT    = 4'd2,
    S_SEND_ID    = 4'd3,
    S_SEND_COLON = 4'd4,
    S_SEND_DIGIT = 4'd5,
    S_SEND_CR    = 4'd6,
    S_SEND_LF    = 4'd7
  } state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_value [N_CH];
  logic [N_CH-1:0]      r_pending;
  logic [N_CH-1:0]      r_overrun;
  logic [c_ch_w-1:0]    r_ch;
  logic [c_ch_w-1:0]    r_last;
  logic [DATA_W-1:0]    r_shift;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_dig_w-1:0]   r_dcnt;
  logic                 r_sat;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_busy;

  logic [N_CH-1:0]      w_clear;
  logic                 w_grant_any;
  logic [c_ch_w-1:0]    w_grant;
  logic [c_bcd_w-1:0]   w_bcd_step;
  logic [c_bcd_w-1:0]   w_bcd_sl;
  logic                 w_xfer;

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign overrun  = r_overrun;
  assign w_xfer   = r_tx_valid && tx_ready;
  assign w_bcd_sl = r_bcd << 4;

  function automatic logic [7:0] digit_byte(input logic sat, input logic [3:0] nib);
    return sat ? 8'h39 : {4'h3, nib};
  endfunction

  always_comb begin
    w_clear = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      w_clear[ch] = (r_state == S_LOAD) && (r_ch == c_ch_w'(ch));
    end
  end

  // Walk from the farthest candidate to the nearest so the nearest pending
  // channel after last_served is the one left in w_grant.
  always_comb begin
    int idx;
    w_grant_any = 1'b0;
    w_grant     = '0;
    idx         = 0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(r_last) + k) % N_CH;
      if (r_pending[idx]) begin
        w_grant_any = 1'b1;
        w_grant     = c_ch_w'(idx);
      end
    end
  end

  always_comb begin
    logic [c_bcd_w-1:0] adj;
    adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
    w_bcd_step = (adj << 1) | c_bcd_w'(r_shift[DATA_W-1]);
  end

  // A new sample in the same cycle as LOAD's clear keeps the channel pending.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int ch = 0; ch < N_CH; ch++) r_value[ch] <= '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (sample_valid[ch]) begin
          r_value[ch]   <= sample_data[ch*DATA_W +: DATA_W];
          r_pending[ch] <= 1'b1;
          if (r_pending[ch] && !w_clear[ch]) r_overrun[ch] <= 1'b1;
        end else if (w_clear[ch]) begin
          r_pending[ch] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_last     <= c_ch_w'(N_CH - 1);
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_dcnt     <= '0;
      r_sat      <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_ch    <= w_grant;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_shift <= r_value[r_ch];
          r_last  <= r_ch;
          r_sat   <= 64'(r_value[r_ch]) > c_max_val;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= S_CONVERT;
        end
        S_CONVERT: begin
          r_bcd   <= w_bcd_step;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_w'(DATA_W - 1)) begin
            r_tx_data  <= 8'h41 + 8'(r_ch);
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND_ID;
          end
        end
        S_SEND_ID: begin
          if (w_xfer) begin
            r_tx_data <= 8'h3A;
            r_state   <= S_SEND_COLON;
          end
        end
        S_SEND_COLON: begin
          if (w_xfer) begin
            r_tx_data <= digit_byte(r_sat, r_bcd[c_bcd_w-1 -: 4]);
            r_dcnt    <= '0;
            r_state   <= S_SEND_DIGIT;
          end
        end
        S_SEND_DIGIT: begin
          if (w_xfer) begin
            if (r_dcnt == c_dig_w'(DIGITS - 1)) begin
              r_tx_data <= 8'h0D;
              r_state   <= S_SEND_CR;
            end else begin
              r_dcnt    <= r_dcnt + 1'b1;
              r_bcd     <= w_bcd_sl;
              r_tx_data <= digit_byte(r_sat, w_bcd_sl[c_bcd_w-1 -: 4]);
            end
          end
        end
        S_SEND_CR: begin
          if (w_xfer) begin
            r_tx_data <= 8'h0A;
            r_state   <= S_SEND_LF;
          end
        end
        S_SEND_LF: begin
          if (w_xfer) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dist_telemetry_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dist_telemetry_framer
// Brief    : Scoreboard bench for dist_telemetry_framer (default and 10-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dist_telemetry_framer;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [1:0]  sample_valid;
  logic [15:0] sample_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy;
  logic [1:0]  overrun;

  logic [1:0]  sample_valid10;
  logic [19:0] sample_data10;
  logic [7:0]  tx_data10;
  logic        tx_valid10, tx_ready10, busy10;
  logic [1:0]  overrun10;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp10_q[$];
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;

  always #5 clk = ~clk;

  dist_telemetry_framer #(.N_CH(2), .DATA_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .reset_p(reset_p), .sample_valid(sample_valid), .sample_data(sample_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
  );

  dist_telemetry_framer #(.N_CH(2), .DATA_W(10), .DIGITS(3)) u_dut10 (
    .clk(clk), .reset_p(reset_p), .sample_valid(sample_valid10), .sample_data(sample_data10),
    .tx_data(tx_data10), .tx_valid(tx_valid10), .tx_ready(tx_ready10), .busy(busy10),
    .overrun(overrun10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input string s, input bit to10);
    for (int i = 0; i < s.len(); i++) begin
      if (to10) exp10_q.push_back(s[i]); else exp_q.push_back(s[i]);
    end
    if (to10) begin exp10_q.push_back(8'h0D); exp10_q.push_back(8'h0A); end
    else      begin exp_q.push_back(8'h0D);   exp_q.push_back(8'h0A);   end
  endtask

  // Called at posedge+1; the strobe is captured at the following edge.
  task automatic pulse(input int ch, input int val);
    sample_valid[ch] = 1'b1;
    sample_data[ch*8 +: 8] = 8'(val);
    @(posedge clk); #1;
    sample_valid = '0;
  endtask

  task automatic pulse10(input int val);
    sample_valid10[0] = 1'b1;
    sample_data10[9:0] = 10'(val);
    @(posedge clk); #1;
    sample_valid10 = '0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy || exp10_q.size() != 0 || busy10) && n < maxc) begin
      @(posedge clk); #1;
      if (name == "b_stall") tx_ready = 1'($urandom_range(0, 1));
      n++;
    end
    tx_ready = 1'b1;
    check({name, "_drain"}, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!tx_valid && n < maxc) begin @(posedge clk); #1; n++; end
    check("wait_valid", 32'(tx_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset_p) begin
      stalled = 1'b0;
    end else if (tx_valid) begin
      if (stalled) check("stall_hold", 32'(tx_data), 32'(held));
      if (tx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF);
        else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        xfer_cnt++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = tx_data;
      end
    end else begin
      if (stalled) check("valid_dropped", 32'(tx_valid), 32'd1);
      stalled = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset_p && tx_valid10 && tx_ready10) begin
      if (exp10_q.size() == 0) check("unexpected_byte10", 32'(tx_data10), 32'hFFFF);
      else check("byte10", 32'(tx_data10), 32'(exp10_q.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int n;
    reset_p = 1'b1;
    sample_valid = '0; sample_data = '0; tx_ready = 1'b1;
    sample_valid10 = '0; sample_data10 = '0; tx_ready10 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_p = 1'b0;
    @(posedge clk); #1;

    // Frame latency from a single strobe on an idle block
    push_frame("A:123", 1'b0);
    pulse(0, 123);
    cyc = 1;
    check("busy_grant_cycle", 32'(busy), 32'd0);
    while (!tx_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("first_valid_cycle", 32'(cyc), 32'd11);
    wait_idle("a123", 100);
    check("overrun_a123", 32'(overrun), 32'd0);

    // Random backpressure
    push_frame("B:007", 1'b0);
    pulse(1, 7);
    wait_idle("b_stall", 400);
    repeat (20) @(posedge clk);
    #1;

    // Simultaneous samples then a late ch0 sample: round-robin order
    push_frame("A:045", 1'b0);
    push_frame("B:200", 1'b0);
    sample_valid = 2'b11;
    sample_data = {8'd200, 8'd45};
    @(posedge clk); #1;
    sample_valid = '0;
    wait_valid(40);
    pulse(0, 9);
    push_frame("A:009", 1'b0);
    wait_idle("rr", 200);
    check("overrun_rr", 32'(overrun), 32'd0);

    // ch1 overwritten while ch0 frame is in flight
    push_frame("A:001", 1'b0);
    push_frame("B:020", 1'b0);
    pulse(0, 1);
    wait_valid(40);
    pulse(1, 10);
    @(posedge clk); #1;
    pulse(1, 20);
    wait_idle("ovr", 200);
    check("overrun_set", 32'(overrun), 32'h2);
    repeat (5) @(posedge clk);
    #1;
    check("overrun_held", 32'(overrun), 32'h2);

    // Saturation on the 10-bit instance
    push_frame("A:999", 1'b1);
    pulse10(1023);
    wait_idle("sat1023", 100);
    push_frame("A:999", 1'b1);
    pulse10(999);
    wait_idle("sat999", 100);
    push_frame("A:999", 1'b1);
    pulse10(1000);
    wait_idle("sat1000", 100);

    // Reset mid-frame with ch1 pending
    exp_q.push_back(8'h41); exp_q.push_back(8'h3A); exp_q.push_back(8'h30);
    base = xfer_cnt;
    pulse(0, 77);
    pulse(1, 50);
    n = 0;
    while (xfer_cnt < base + 3 && n < 100) begin @(posedge clk); #1; n++; end
    check("reach_third_byte", 32'(n < 100), 32'd1);
    #1 reset_p = 1'b1;
    #1;
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    reset_p = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);
    push_frame("A:005", 1'b0);
    pulse(0, 5);
    wait_idle("post_rst", 100);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp10_q_empty", 32'(exp10_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dist_telemetry_framer.md
# dist_telemetry_framer

Parametrised N-channel distance telemetry framer. It sits between the ultrasonic ranging front-ends and the UART transmitter. It latches per-channel distance samples and arbitrates among pending channels round-robin. It converts each sample to fixed-width decimal ASCII and streams one frame per sample, `<ID>:<digits>\r\n`, over a valid/ready byte interface. It replaces the fixed two-input ASCII mux path and adds multi-digit conversion, arbitration, backpressure and overrun reporting.

## Interface
- N_CH, 2, number of distance channels (1..8); channel IDs are ASCII 'A'+ch
- DATA_W, 8, distance sample width in bits (cm)
- DIGITS, 3, decimal digits per frame; frame length = DIGITS+4 bytes

- clk  in  1  system clock
- reset_p  in  1  reset; one clock, asynchronous, active-high
- sample_valid  in  N_CH  one-cycle strobe per channel; new sample present
- sample_data  in  N_CH*DATA_W  channel ch occupies bits [ch*DATA_W +: DATA_W]
- tx_data  out  8  ASCII byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- busy  out  1  high whenever state != IDLE
- overrun  out  N_CH  sticky per-channel flag; sample overwritten before being framed

## Operation
- Per channel: value register (DATA_W) and pending bit. sample_valid[ch]=1 loads value[ch] and sets pending[ch].
- Overrun: sample_valid[ch] while pending[ch]=1 and pending[ch] is not cleared that cycle. The new value overwrites the old one and overrun[ch] is set. overrun is cleared only by reset.
- Arbiter: round-robin. The search starts at last_served+1 mod N_CH. After reset last_served=N_CH-1, so ch0 has first priority.
- FSM states: IDLE, LOAD, CONVERT, SEND_ID, SEND_COLON, SEND_DIGIT, SEND_CR, SEND_LF.
  - IDLE: if any pending, latch granted ch, go to LOAD.
  - LOAD: copy value[ch] to the shift register, clear pending[ch], update last_served, compute sat = (value > 10^DIGITS-1), go to CONVERT.
  - CONVERT: double-dabble, exactly DATA_W cycles. It uses a DIGITS*4-bit BCD register, and overflow above the top digit is discarded. Then go to SEND_ID.
  - SEND_ID ('A'+ch) → SEND_COLON (0x3A) → SEND_DIGIT (DIGITS bytes, most significant first, leading zeros kept, each byte 0x30+digit) → SEND_CR (0x0D) → SEND_LF (0x0A) → IDLE.
- Saturation: if sat=1, every digit byte is '9' (0x39). CONVERT length is unchanged.
- Simultaneous sample_valid[ch] and LOAD clearing pending[ch]: set wins. pending stays 1 with the new value, and overrun is not set. LOAD captures the old value.
- Samples arriving during any send state are only latched. An in-flight frame never changes.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, busy=0, overrun=0, all pending=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). No partial-frame resumption occurs after release.
- Byte handshake: tx_valid=1 in every SEND_* state. tx_data is stable while tx_valid=1 and tx_ready=0. A transfer occurs on a rising edge with tx_valid&tx_ready, and the FSM advances on that edge. tx_valid never drops without a transfer, except on reset.
- With tx_ready held 1, each byte takes one cycle.
- Latency, idle block, sample_valid in cycle 0:
  - cycle 1: IDLE grants
  - cycle 2: LOAD
  - cycles 3..DATA_W+2: CONVERT
  - cycle DATA_W+3: first tx_valid (11 with defaults)
- Frame with continuous ready = 2+DATA_W+DIGITS+4 cycles. The next frame's IDLE follows SEND_LF, so there is one idle cycle between back-to-back frames.
- busy is high from LOAD through the final SEND_LF transfer cycle.

## Test plan
- Defaults, ch0 sample 123 at cycle 0, tx_ready=1 → bytes 0x41,0x3A,0x31,0x32,0x33,0x0D,0x0A; first tx_valid at cycle 11; overrun=00.
- ch1 sample 7, tx_ready toggled pseudo-randomly → "B:007\r\n" exactly once; tx_data is constant across every stalled cycle.
- ch0=45 and ch1=200 in the same cycle, then ch0=9 after the first frame starts → order "A:045", "B:200", "A:009" (round-robin); overrun=00.
- ch1=10 then ch1=20 while the ch0 frame is in flight → ch1 frame "B:020" only; overrun=2'b10, held until reset.
- DATA_W=10, DIGITS=3, ch0=1023 → "A:999\r\n"; ch0=999 → "A:999\r\n"; ch0=1000 → "A:999\r\n".
- reset_p pulsed after the 3rd byte transfer, with ch1 pending → tx_valid=0 and busy=0 in the same cycle; no bytes after release; a new ch0=5 sample yields "A:005\r\n".
